// File: rtl/xf100_exu_muldiv_if.sv
// rtl/xf100_exu_muldiv_if.sv - issue/write-back bundle between the EXU and the mul/div unit
interface xf100_exu_muldiv_if #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
);
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_op;
    logic [XLEN-1:0]    req_rs1;
    logic [XLEN-1:0]    req_rs2;
    logic [RFIDX_W-1:0] req_rdidx;
    logic               flush;
    logic               busy;
    logic [RFIDX_W-1:0] busy_rdidx;
    logic               wbck_ready;
    logic               wbck_en;
    logic [XLEN-1:0]    wbck_data;
    logic [RFIDX_W-1:0] wbck_rdidx;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rdidx, flush, wbck_ready,
        input  req_ready, busy, busy_rdidx, wbck_en, wbck_data, wbck_rdidx
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rdidx, flush, wbck_ready,
        output req_ready, busy, busy_rdidx, wbck_en, wbck_data, wbck_rdidx
    );
endinterface

// File: rtl/xf100_exu_muldiv.sv
// rtl/xf100_exu_muldiv.sv - iterative RV32M multiply/divide unit feeding write-back source 1
module xf100_exu_muldiv #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xf100_exu_muldiv_if.slave    bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0]   L_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] L_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_op;
    logic [RFIDX_W-1:0]  r_rdidx;
    logic                r_neg;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_res;

    logic                w_idle;
    logic                w_done;
    logic                w_ready;
    logic                w_accept;
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_neg;
    logic                w_div0;
    logic                w_ovf;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_shift;
    logic [XLEN+1:0]     w_div_diff;
    logic                w_div_ok;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quo_s;
    logic [XLEN-1:0]     w_rem_s;
    logic [XLEN-1:0]     w_fix_res;

    assign w_idle   = (r_state == S_IDLE);
    assign w_done   = (r_state == S_DONE);
    assign w_ready  = w_idle && !bus.flush;
    assign w_accept = bus.req_valid && w_ready;

    // Operand signedness: divides follow op[0]; MULHSU keeps rs1 signed, MULHU neither.
    assign w_is_div   = bus.req_op[2];
    assign w_a_signed = w_is_div ? !bus.req_op[0] : (bus.req_op[1:0] != 2'b11);
    assign w_b_signed = w_is_div ? !bus.req_op[0] : !bus.req_op[1];
    assign w_a_neg    = w_a_signed && bus.req_rs1[XLEN-1];
    assign w_b_neg    = w_b_signed && bus.req_rs2[XLEN-1];
    assign w_a_mag    = w_a_neg ? -bus.req_rs1 : bus.req_rs1;
    assign w_b_mag    = w_b_neg ? -bus.req_rs2 : bus.req_rs2;
    assign w_neg      = (w_is_div && bus.req_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div0 = w_is_div && (bus.req_rs2 == '0);
    assign w_ovf  = w_is_div && !bus.req_op[0] && (bus.req_rs1 == L_MIN) && (bus.req_rs2 == '1);

    always_comb begin
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = bus.req_op[1] ? bus.req_rs1 : '1;
        end else begin
            w_special_res = bus.req_op[1] ? '0 : L_MIN;
        end
    end

    // r_hi:r_lo is the product (multiply) or partial remainder:dividend/quotient (divide).
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b0, r_b};
    assign w_div_ok    = !w_div_diff[XLEN+1];

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_quo_s  = r_neg ? -r_lo : r_lo;
    assign w_rem_s  = r_neg ? -r_hi : r_hi;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            3'd0:                w_fix_res = w_prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_fix_res = w_quo_s;
            default:             w_fix_res = w_rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rdidx <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.req_op;
                        r_rdidx <= bus.req_rdidx;
                        r_neg   <= w_neg;
                        r_hi    <= '0;
                        r_lo    <= w_a_mag;
                        r_b     <= w_b_mag;
                        r_cnt   <= '0;
                        if (w_div0 || w_ovf) begin
                            r_res   <= w_special_res;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_op[2]) begin
                        r_hi <= w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_div_ok};
                    end else begin
                        r_hi <= w_mul_sum[XLEN:1];
                        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == L_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_res   <= w_fix_res;
                    r_state <= S_DONE;
                end
                default: begin
                    if (bus.wbck_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Write-back outputs are zero-gated: the merge stage ORs all sources together.
    assign bus.req_ready  = w_ready;
    assign bus.busy       = !w_idle;
    assign bus.busy_rdidx = w_idle ? '0 : r_rdidx;
    assign bus.wbck_en    = w_done;
    assign bus.wbck_data  = w_done ? r_res : '0;
    assign bus.wbck_rdidx = w_done ? r_rdidx : '0;
endmodule

// File: tb/tb_xf100_exu_muldiv.sv
// tb/tb_xf100_exu_muldiv.sv - directed self-checking bench for xf100_exu_muldiv
module tb_xf100_exu_muldiv;
    logic clk;
    logic rst_n;

    xf100_exu_muldiv_if #(.XLEN(32), .RFIDX_W(5)) bus ();

    xf100_exu_muldiv #(.XLEN(32), .RFIDX_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] lit;
        bit          has_lit;
    } vec_t;

    vec_t vecs[$];

    int          n_asrt;
    int          n_fail;
    int          cyc;
    bit          pending;
    int          exp_at;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    int          en_cnt;
    int          t_acc;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(int'(a) / int'(b));
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(int'(a) % int'(b));
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] lit, input bit has_lit);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rd = rd; v.lit = lit; v.has_lit = has_lit;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_asrt++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Per-cycle write-back check against the scoreboard, sampled on the falling edge.
    task automatic at_neg();
        bit want;
        @(negedge clk);
        if (rst_n) begin
            want = pending && (cyc >= exp_at);
            chk("wbck_en", {31'b0, bus.wbck_en}, {31'b0, want});
            if (!bus.wbck_en) begin
                chk("idle_wbck_data", bus.wbck_data, 32'd0);
                chk("idle_wbck_rdidx", {27'b0, bus.wbck_rdidx}, 32'd0);
            end else if (want) begin
                chk("wbck_data", bus.wbck_data, exp_data);
                chk("wbck_rdidx", {27'b0, bus.wbck_rdidx}, {27'b0, exp_rd});
                en_cnt++;
                if (bus.wbck_ready) pending = 1'b0;
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic tick();
        at_neg();
        to_pos();
    endtask

    task automatic start(input vec_t v, input int hold);
        logic [31:0] m;
        m = model(v.op, v.a, v.b);
        if (v.has_lit) chk("model_literal", m, v.lit);
        t_acc    = cyc;
        exp_at   = cyc + latency(v.op, v.a, v.b);
        exp_data = m;
        exp_rd   = v.rd;
        en_cnt   = 0;
        pending  = 1'b1;
        bus.wbck_ready = (hold == 0);
        bus.req_valid  = 1'b1;
        bus.req_op     = v.op;
        bus.req_rs1    = v.a;
        bus.req_rs2    = v.b;
        bus.req_rdidx  = v.rd;
        at_neg();
        chk("req_ready_accept", {31'b0, bus.req_ready}, 32'd1);
        to_pos();
        bus.req_valid = 1'b0;
        bus.req_rs1   = 32'd0;
        bus.req_rs2   = 32'd0;
        at_neg();
        chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
        chk("busy_rdidx", {27'b0, bus.busy_rdidx}, {27'b0, v.rd});
        chk("req_ready_busy", {31'b0, bus.req_ready}, 32'd0);
        to_pos();
    endtask

    task automatic issue(input vec_t v, input int hold);
        start(v, hold);
        for (int k = 0; k < 80 && pending; k++) begin
            if (cyc >= exp_at + hold) bus.wbck_ready = 1'b1;
            tick();
        end
        if (pending) begin
            n_asrt++;
            n_fail++;
            $display("FAIL wbck_timeout: no write-back handshake for op %0d", v.op);
            pending = 1'b0;
        end
        at_neg();
        chk("req_ready_after", {31'b0, bus.req_ready}, 32'd1);
        chk("busy_after", {31'b0, bus.busy}, 32'd0);
        chk("wbck_en_cycles", en_cnt, hold + 1);
        to_pos();
        bus.wbck_ready = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, "_busy_rdidx"}, {27'b0, bus.busy_rdidx}, 32'd0);
        chk({tag, "_wbck_en"}, {31'b0, bus.wbck_en}, 32'd0);
        chk({tag, "_wbck_data"}, bus.wbck_data, 32'd0);
        chk({tag, "_wbck_rdidx"}, {27'b0, bus.wbck_rdidx}, 32'd0);
    endtask

    initial begin
        n_asrt = 0; n_fail = 0; cyc = 0; pending = 1'b0; exp_at = 0;
        exp_data = '0; exp_rd = '0; en_cnt = 0; t_acc = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        bus.req_rdidx = '0; bus.flush = 1'b0; bus.wbck_ready = 1'b1;

        add(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1);
        add(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1);
        add(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 1);
        add(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF, 1);
        add(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 1);
        add(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 1);
        add(3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        1);
        add(3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         1);
        add(3'd5, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1);
        add(3'd6, 32'd5,          32'd0,         5'd10, 32'd5,         1);
        add(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
        add(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1);
        add(3'd3, 32'h1234_5678,  32'h9ABC_DEF0, 5'd0,  32'd0,         0);
        add(3'd0, 32'h1234_5678,  32'h9ABC_DEF0, 5'd31, 32'd0,         0);
        add(3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         0);
        add(3'd4, 32'h8000_0000,  32'd3,         5'd14, 32'd0,         0);
        add(3'd7, 32'hFFFF_FFFF,  32'd10,        5'd15, 32'd0,         0);
        add(3'd6, 32'd17,         32'hFFFF_FFFB, 5'd16, 32'd0,         0);
        add(3'd5, 32'hFFFF_FFFF,  32'd1,         5'd17, 32'd0,         0);
        add(3'd4, 32'h8000_0000,  32'd1,         5'd18, 32'd0,         0);

        to_pos();
        to_pos();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) issue(vecs[i], 0);

        // Stall the write-back grant in DONE, on a computed and a special-case result.
        issue(vecs[0], 3);
        issue(vecs[8], 2);

        // Flush inside CALC kills the op without any write-back.
        start(vecs[6], 0);
        while (cyc < t_acc + 10) tick();
        bus.flush = 1'b1;
        pending = 1'b0;
        tick();
        bus.flush = 1'b0;
        at_neg();
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);
        chk("flush_req_ready", {31'b0, bus.req_ready}, 32'd1);
        to_pos();
        repeat (40) tick();

        // Flush in IDLE blocks a simultaneous request.
        bus.flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op = 3'd0; bus.req_rs1 = 32'd3; bus.req_rs2 = 32'd4; bus.req_rdidx = 5'd9;
        at_neg();
        chk("flush_idle_req_ready", {31'b0, bus.req_ready}, 32'd0);
        to_pos();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        at_neg();
        chk("flush_idle_no_accept", {31'b0, bus.busy}, 32'd0);
        to_pos();

        // Reset mid-operation returns everything to reset values at once.
        start(vecs[1], 0);
        while (cyc < t_acc + 20) tick();
        rst_n = 1'b0;
        pending = 1'b0;
        #1;
        chk_reset_outputs("midop_reset");
        to_pos();
        rst_n = 1'b1;
        repeat (40) tick();

        issue(vecs[4], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
